// File: rtl/cache_ctrl_param.sv
// Parametrised 2-way set-associative, write-through, no-write-allocate data cache between MEM stage and backing memory.
// Latency: read hit returns data in the request cycle; misses and all stores stall until the backing mem_ready pulse.
// Backpressure: freeze is combinational; it is held high while a request is pending and drops in its completion cycle.
//
// Ports: clk/rst (async active-high); addr, data_in, MEM_R_en, MEM_W_en from MEM stage; data_out, freeze back to it;
// mem_r_req/mem_w_req/mem_addr/mem_wdata/mem_rdata/mem_ready towards backing memory; hit_cnt/miss_cnt saturating stats.
module cache_ctrl_param #(
    parameter int ADDR_W    = 18,
    parameter int INDEX_LEN = 6,
    parameter int OFFS_LEN  = 1,
    parameter int CNT_W     = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [ADDR_W-1:0]           addr,
    input  logic [31:0]                 data_in,
    input  logic                        MEM_R_en,
    input  logic                        MEM_W_en,
    output logic [31:0]                 data_out,
    output logic                        freeze,
    output logic                        mem_r_req,
    output logic                        mem_w_req,
    output logic [ADDR_W-1:0]           mem_addr,
    output logic [31:0]                 mem_wdata,
    input  logic [(32<<OFFS_LEN)-1:0]   mem_rdata,
    input  logic                        mem_ready,
    output logic [CNT_W-1:0]            hit_cnt,
    output logic [CNT_W-1:0]            miss_cnt
);

    localparam int SETS    = 1 << INDEX_LEN;
    localparam int LINE_W  = 32 << OFFS_LEN;
    localparam int TAG_LEN = ADDR_W - INDEX_LEN - OFFS_LEN - 2;
    localparam int IDX_LO  = OFFS_LEN + 2;
    localparam int TAG_LO  = IDX_LO + INDEX_LEN;

    localparam logic [ADDR_W-1:0] WORD_MASK = ~ADDR_W'(3);
    localparam logic [ADDR_W-1:0] LINE_MASK = ~((ADDR_W'(1) << IDX_LO) - ADDR_W'(1));

    typedef enum logic [1:0] {IDLE, RMISS, WTHRU} state_t;

    state_t state_q, state_d;
    logic              mem_r_req_q, mem_r_req_d;
    logic              mem_w_req_q, mem_w_req_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [31:0]       mem_wdata_q, mem_wdata_d;
    logic [CNT_W-1:0]  hit_cnt_q, hit_cnt_d;
    logic [CNT_W-1:0]  miss_cnt_q, miss_cnt_d;

    // Set storage; lru_q holds the way to evict next.
    logic [SETS-1:0]    valid0_q, valid1_q, lru_q;
    logic [TAG_LEN-1:0] tag0_q  [SETS];
    logic [TAG_LEN-1:0] tag1_q  [SETS];
    logic [LINE_W-1:0]  line0_q [SETS];
    logic [LINE_W-1:0]  line1_q [SETS];

    // Single line-write port shared by fills and write-hit updates.
    logic                 st_en, st_way;
    logic [INDEX_LEN-1:0] st_idx;
    logic [TAG_LEN-1:0]   st_tag;
    logic [LINE_W-1:0]    st_line;
    logic                 lru_we, lru_val;
    logic [INDEX_LEN-1:0] lru_idx;

    // Request fields come from the live address; pending fields from the
    // registered backing address so a dropped request still lands correctly.
    logic [OFFS_LEN-1:0]  req_off, pend_off;
    logic [INDEX_LEN-1:0] req_idx, pend_idx;
    logic [TAG_LEN-1:0]   req_tag, pend_tag;
    logic                 req_hit0, req_hit1, pend_hit0, pend_hit1, victim;
    logic [LINE_W-1:0]    pend_line;

    function automatic logic [31:0] pick(input logic [LINE_W-1:0] line, input logic [OFFS_LEN-1:0] off);
        logic [LINE_W-1:0] sh;
        sh = line >> {off, 5'b0};
        return sh[31:0];
    endfunction

    function automatic logic [LINE_W-1:0] merge(input logic [LINE_W-1:0] line, input logic [OFFS_LEN-1:0] off,
                                                input logic [31:0] w);
        logic [LINE_W-1:0] mask;
        mask = {{(LINE_W-32){1'b0}}, 32'hFFFF_FFFF} << {off, 5'b0};
        return (line & ~mask) | ({{(LINE_W-32){1'b0}}, w} << {off, 5'b0});
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (c == {CNT_W{1'b1}}) ? c : c + CNT_W'(1);
    endfunction

    always_comb begin
        req_off   = addr[IDX_LO-1:2];
        req_idx   = addr[TAG_LO-1:IDX_LO];
        req_tag   = addr[ADDR_W-1:TAG_LO];
        pend_off  = mem_addr_q[IDX_LO-1:2];
        pend_idx  = mem_addr_q[TAG_LO-1:IDX_LO];
        pend_tag  = mem_addr_q[ADDR_W-1:TAG_LO];
        req_hit0  = valid0_q[req_idx] && (tag0_q[req_idx] == req_tag);
        req_hit1  = valid1_q[req_idx] && (tag1_q[req_idx] == req_tag);
        pend_hit0 = valid0_q[pend_idx] && (tag0_q[pend_idx] == pend_tag);
        pend_hit1 = valid1_q[pend_idx] && (tag1_q[pend_idx] == pend_tag);
        pend_line = pend_hit1 ? line1_q[pend_idx] : line0_q[pend_idx];
        // Invalid way first, otherwise the LRU way.
        if (!valid0_q[pend_idx])      victim = 1'b0;
        else if (!valid1_q[pend_idx]) victim = 1'b1;
        else                          victim = lru_q[pend_idx];
    end

    always_comb begin
        state_d     = state_q;
        mem_r_req_d = mem_r_req_q;
        mem_w_req_d = mem_w_req_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        hit_cnt_d   = hit_cnt_q;
        miss_cnt_d  = miss_cnt_q;
        freeze      = 1'b0;
        data_out    = 32'h0;
        st_en       = 1'b0;
        st_way      = 1'b0;
        st_idx      = pend_idx;
        st_tag      = pend_tag;
        st_line     = mem_rdata;
        lru_we      = 1'b0;
        lru_val     = 1'b0;
        lru_idx     = pend_idx;

        unique case (state_q)
            IDLE: begin
                if (MEM_W_en) begin
                    freeze      = 1'b1;
                    state_d     = WTHRU;
                    mem_w_req_d = 1'b1;
                    mem_addr_d  = addr & WORD_MASK;
                    mem_wdata_d = data_in;
                end else if (MEM_R_en) begin
                    if (req_hit0 || req_hit1) begin
                        data_out  = req_hit1 ? pick(line1_q[req_idx], req_off) : pick(line0_q[req_idx], req_off);
                        lru_we    = 1'b1;
                        lru_idx   = req_idx;
                        lru_val   = !req_hit1;
                        hit_cnt_d = sat_inc(hit_cnt_q);
                    end else begin
                        freeze      = 1'b1;
                        state_d     = RMISS;
                        mem_r_req_d = 1'b1;
                        mem_addr_d  = addr & LINE_MASK;
                        miss_cnt_d  = sat_inc(miss_cnt_q);
                    end
                end
            end
            RMISS: begin
                if (mem_ready) begin
                    data_out    = MEM_R_en ? pick(mem_rdata, req_off) : 32'h0;
                    st_en       = 1'b1;
                    st_way      = victim;
                    lru_we      = 1'b1;
                    lru_val     = !victim;
                    mem_r_req_d = 1'b0;
                    state_d     = IDLE;
                end else begin
                    freeze = MEM_R_en || MEM_W_en;
                end
            end
            WTHRU: begin
                if (mem_ready) begin
                    if (pend_hit0 || pend_hit1) begin
                        st_en   = 1'b1;
                        st_way  = pend_hit1;
                        st_line = merge(pend_line, pend_off, mem_wdata_q);
                        lru_we  = 1'b1;
                        lru_val = !pend_hit1;
                    end
                    mem_w_req_d = 1'b0;
                    state_d     = IDLE;
                end else begin
                    freeze = MEM_R_en || MEM_W_en;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            mem_r_req_q <= 1'b0;
            mem_w_req_q <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            hit_cnt_q   <= '0;
            miss_cnt_q  <= '0;
            valid0_q    <= '0;
            valid1_q    <= '0;
            lru_q       <= '0;
        end else begin
            state_q     <= state_d;
            mem_r_req_q <= mem_r_req_d;
            mem_w_req_q <= mem_w_req_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            hit_cnt_q   <= hit_cnt_d;
            miss_cnt_q  <= miss_cnt_d;
            if (st_en) begin
                if (st_way) valid1_q[st_idx] <= 1'b1;
                else        valid0_q[st_idx] <= 1'b1;
            end
            if (lru_we) lru_q[lru_idx] <= lru_val;
        end
    end

    // Tags and data need no reset: they are only visible through valid bits.
    always_ff @(posedge clk) begin
        if (st_en) begin
            if (st_way) begin
                tag1_q[st_idx]  <= st_tag;
                line1_q[st_idx] <= st_line;
            end else begin
                tag0_q[st_idx]  <= st_tag;
                line0_q[st_idx] <= st_line;
            end
        end
    end

    assign mem_r_req = mem_r_req_q;
    assign mem_w_req = mem_w_req_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign hit_cnt   = hit_cnt_q;
    assign miss_cnt  = miss_cnt_q;

endmodule

// File: doc/cache_ctrl_param.md
Name: cache_ctrl_param

Overview:
Parametrised 2-way set-associative, write-through, no-write-allocate data cache between the MEM stage and a backing-memory controller (SRAM controller or similar).
- Generalises the fixed 18-bit/64-set/2-word cache: address width, set count and line length are parameters.
- Write hits now update the cached line instead of invalidating it.
- Fill victim prefers an invalid way over LRU.
- The backing side is a generic req/ready handshake carrying a full line, with saturating hit/miss counters.

Parameters:
ADDR_W, 18, byte-address width; bits [1:0] ignored (word aligned).
INDEX_LEN, 6, set-index bits; sets = 2**INDEX_LEN.
OFFS_LEN, 1, word-offset bits; words per line = 2**OFFS_LEN (legal 1..3).
CNT_W, 16, width of the hit and miss counters.
Derived: LINE_W = 32*2**OFFS_LEN; TAG_LEN = ADDR_W-INDEX_LEN-OFFS_LEN-2.

Ports:
clk  in  1  clock, rising edge.
rst  in  1  asynchronous active-high reset.
addr  in  ADDR_W  byte address from MEM stage.
data_in  in  32  store data.
MEM_R_en  in  1  load request.
MEM_W_en  in  1  store request.
data_out  out  32  load data.
freeze  out  1  stall pipeline (combinational).
mem_r_req  out  1  line-read request to backing memory.
mem_w_req  out  1  word-write request to backing memory.
mem_addr  out  ADDR_W  backing address; line-aligned for reads, word-aligned for writes.
mem_wdata  out  32  write data.
mem_rdata  in  LINE_W  fill line; word k at bits [32k+31:32k].
mem_ready  in  1  one-cycle completion pulse for the current request.
hit_cnt  out  CNT_W  read-hit count.
miss_cnt  out  CNT_W  read-miss count.

Behaviour:
- Address split: offset = addr[OFFS_LEN+1:2]; index = next INDEX_LEN bits; tag = top TAG_LEN bits.
- Per set: valid0, tag0, line0, valid1, tag1, line1, lru. lru = victim way.
- Hit definition: hit_w = valid_w & (tag_w == tag). Both ways never hold the same tag.
- On reset (async): all valid bits = 0, all lru = 0, state IDLE, mem_r_req = mem_w_req = 0, mem_addr = 0, mem_wdata = 0, counters = 0, data_out = 0. Reset mid-miss abandons the transaction; a late mem_ready is ignored.
- FSM states: IDLE, RMISS, WTHRU.
- IDLE, MEM_W_en = 1:
  - Next state WTHRU; freeze = 1.
  - Next edge: mem_w_req = 1, mem_addr = addr & ~3, mem_wdata = data_in.
  - MEM_W_en has priority if both enables are high.
- IDLE, MEM_R_en = 1, hit:
  - freeze = 0; data_out = hit way word[offset] the same cycle (zero-latency).
  - At the edge: lru <= ~hit way; hit_cnt increments.
- IDLE, MEM_R_en = 1, miss:
  - freeze = 1; next state RMISS.
  - mem_r_req = 1 from the next edge; mem_addr = line-aligned addr.
  - miss_cnt increments once per miss.
- RMISS:
  - Hold mem_r_req until mem_ready.
  - In the mem_ready cycle: freeze = 0, data_out = mem_rdata word[offset].
  - At that edge: write line into victim (way0 if !valid0, else way1 if !valid1, else lru), set valid and tag, lru <= ~victim, mem_r_req <= 0, state IDLE.
- WTHRU:
  - Hold mem_w_req until mem_ready; in the mem_ready cycle freeze = 0.
  - At that edge, if the address hits a way: replace word[offset] in that line and set lru <= ~way.
  - Miss: cache is unchanged (no allocate). mem_w_req <= 0; state IDLE.
- freeze = 1 whenever a request is pending and not completing this cycle. freeze = 0 when no request is present.
- data_out = 0 when no read is completing.
- MEM stage holds addr, data_in and the enables stable while freeze = 1.
- If the request is dropped mid-transaction, the transaction still completes and the fill/update still happens, with no output.
- mem_ready in IDLE is ignored.
- Back-to-back: a new request may be presented the cycle after completion; it is evaluated in IDLE that cycle, so a hit after a fill has zero latency.
- Counters saturate at 2**CNT_W-1; they never wrap.

Test Plan:
1. Reset, read 0x00100 → miss: freeze 1, mem_r_req with mem_addr 0x00100; ready with line {0xBBBB, 0xAAAA} → data_out 0xAAAA, miss_cnt 1. Re-read 0x00104 → same-cycle 0xBBBB, freeze 0, hit_cnt 1.
2. Fill tags 1 and 2 into set 0, read tag 1 (lru → way of tag 2), read tag 3 → tag 2 evicted; tag 1 still hits.
3. Write 0x1234 to cached 0x00100 → mem_w_req with mem_addr 0x00100, mem_wdata 0x1234, freeze held until ready; following read 0x00100 hits and returns 0x1234.
4. Write to an uncached address → write-through only; next read of it misses (miss_cnt increments).
5. Assert rst during RMISS before mem_ready → mem_r_req drops immediately, all reads miss afterwards; a stray mem_ready is ignored.
6. With CNT_W = 4, perform 20 read hits → hit_cnt stays 15. With OFFS_LEN = 2, a read of offset 3 returns mem_rdata[127:96].
